muldiv_ctrl: RTL and testbench

//   Sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO in the EX stage; sole writer of the HI/LO

---
 rtl/muldiv_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Owns the HI/LO write port: one write pulse per completed op, pipeline stalled while computing.
module muldiv_ctrl #(
    parameter bit MUL_FAST      = 1'b0,
    parameter bit DIV_ZERO_KEEP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        stall_o,
    output logic        done,
    output logic [1:0]  hilo_we,
    output logic [31:0] hilo_hi,
    output logic [31:0] hilo_lo
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_WB
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [CNT_W-1:0]     r_cnt;
    logic [2*XLEN-1:0]    r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]      r_opd;     // mul: |multiplicand|; div: |divisor|
    logic                 r_is_mul;
    logic                 r_neg_q;   // product / quotient must be negated
    logic                 r_neg_r;   // remainder must be negated
    logic [1:0]           r_we;

    logic                 w_op_mul;
    logic                 w_op_div;
    logic                 w_op_mt;
    logic                 w_signed;
    logic                 w_b_zero;
    logic [XLEN-1:0]      w_mag_a;
    logic [XLEN-1:0]      w_mag_b;
    logic [2*XLEN-1:0]    w_fast_prod;
    logic [XLEN:0]        w_mul_sum;
    logic [2*XLEN-1:0]    w_mul_next;
    logic [XLEN:0]        w_div_shift;
    logic [XLEN:0]        w_div_diff;
    logic [2*XLEN-1:0]    w_div_next;
    logic [2*XLEN-1:0]    w_acc_neg;

    // Decode the requested op and take operand magnitudes for the signed forms
    always_comb begin
        w_op_mul    = (op == OP_MULT) || (op == OP_MULTU);
        w_op_div    = (op == OP_DIV)  || (op == OP_DIVU);
        w_op_mt     = (op == OP_MTHI) || (op == OP_MTLO);
        w_signed    = (op == OP_MULT) || (op == OP_DIV);
        w_b_zero    = (src_b == '0);
        w_mag_a     = (w_signed && src_a[XLEN-1]) ? (XLEN'(0) - src_a) : src_a;
        w_mag_b     = (w_signed && src_b[XLEN-1]) ? (XLEN'(0) - src_b) : src_b;
        w_fast_prod = (2*XLEN)'(w_mag_a) * (2*XLEN)'(w_mag_b);
    end

    // One shift-add multiply step and one restoring divide step on the accumulator
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opd};
        w_mul_next  = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:1]};
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opd};
        w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
        w_acc_neg   = (2*XLEN)'(0) - r_acc;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, stall/busy and the cancel-gated write strobe
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        stall_o = 1'b0;
        done    = 1'b0;
        hilo_we = 2'b00;
        case (r_state)
            S_IDLE: begin
                stall_o = start && !cancel && (w_op_mul || w_op_div);
                if (start && !cancel) begin
                    if (w_op_mt) begin
                        w_next = S_WB;
                    end else if (w_op_mul) begin
                        w_next = MUL_FAST ? S_FIX : S_MUL;
                    end else if (w_op_div) begin
                        w_next = w_b_zero ? S_WB : S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                busy    = 1'b1;
                stall_o = 1'b1;
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(31)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy    = 1'b1;
                stall_o = 1'b1;
                w_next  = cancel ? S_IDLE : S_WB;
            end
            S_WB: begin
                busy   = 1'b1;
                w_next = S_IDLE;
                if (!cancel) begin
                    done    = 1'b1;
                    hilo_we = r_we;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration, sign fix-up and HI/LO data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_is_mul <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_we     <= 2'b00;
            hilo_hi  <= '0;
            hilo_lo  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        r_cnt    <= '0;
                        r_is_mul <= w_op_mul;
                        r_neg_q  <= w_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                        r_neg_r  <= w_signed && src_a[XLEN-1];
                        if (w_op_mt) begin
                            if (op == OP_MTHI) begin
                                r_we    <= 2'b10;
                                hilo_hi <= src_a;
                            end else begin
                                r_we    <= 2'b01;
                                hilo_lo <= src_a;
                            end
                        end else if (w_op_mul) begin
                            r_we  <= 2'b11;
                            r_opd <= w_mag_a;
                            r_acc <= MUL_FAST ? w_fast_prod : {XLEN'(0), w_mag_b};
                        end else if (w_op_div) begin
                            if (!w_b_zero) begin
                                r_we  <= 2'b11;
                                r_opd <= w_mag_b;
                                r_acc <= {XLEN'(0), w_mag_a};
                            end else if (DIV_ZERO_KEEP) begin
                                r_we  <= 2'b00;
                            end else begin
                                r_we    <= 2'b11;
                                hilo_hi <= src_a;
                                hilo_lo <= 32'hFFFF_FFFF;
                            end
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!cancel) begin
                        if (r_is_mul) begin
                            {hilo_hi, hilo_lo} <= r_neg_q ? w_acc_neg : r_acc;
                        end else begin
                            hilo_lo <= r_neg_q ? w_acc_neg[XLEN-1:0] : r_acc[XLEN-1:0];
                            hilo_hi <= r_neg_r ? (XLEN'(0) - r_acc[2*XLEN-1:XLEN])
                                               : r_acc[2*XLEN-1:XLEN];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl (default parameters): directed table, corner sequences, random ops.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, stall_o, done;
    logic [1:0]  hilo_we;
    logic [31:0] hilo_hi, hilo_lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  we;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [1:0]  we;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } res_t;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .cancel  (cancel),
        .busy    (busy),
        .stall_o (stall_o),
        .done    (done),
        .hilo_we (hilo_we),
        .hilo_hi (hilo_hi),
        .hilo_lo (hilo_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one op, from plain integer arithmetic
    function automatic res_t ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, q, rm;
        logic [63:0] p, qb, rb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.we = 2'b11; r.hi = m_hi; r.lo = m_lo; r.lat = 34;
        p = '0; qb = '0; rb = '0;
        case (o)
            3'd0, 3'd1: begin
                if (o == 3'd0) p = sa * sb;
                else           p = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    r.we = 2'b00; r.lat = 1;
                end else begin
                    if (o == 3'd2) begin q = sa / sb; rm = sa % sb; end
                    else begin q = longint'(a) / longint'(b); rm = longint'(a) % longint'(b); end
                    qb = q; rb = rm;
                    r.lo = qb[31:0]; r.hi = rb[31:0];
                end
            end
            3'd4: begin r.we = 2'b10; r.hi = a; r.lat = 1; end
            default: begin r.we = 2'b01; r.lo = a; r.lat = 1; end
        endcase
        return r;
    endfunction

    // Issue one op and check stall, latency, write pulse, data and the idle cycle after
    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] ewe, input logic [31:0] ehi,
                         input logic [31:0] elo, input int elat);
        int          cyc, stall_bad;
        bit          seen;
        logic [31:0] xh, xl;
        xh = ewe[1] ? ehi : m_hi;
        xl = ewe[0] ? elo : m_lo;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        chk({name, " stall_c0"}, 64'(stall_o), 64'(o <= 3'd3));
        seen = 1'b0; cyc = 0; stall_bad = 0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            #1;
            if (done) seen = 1'b1;
            else if (stall_o !== 1'b1 || busy !== 1'b1) stall_bad++;
        end
        chk({name, " latency"}, 64'(seen ? cyc : 0), 64'(elat));
        chk({name, " stall_mid"}, 64'(stall_bad), 64'd0);
        if (seen) begin
            chk({name, " we"}, 64'(hilo_we), 64'(ewe));
            chk({name, " hi/lo"}, {hilo_hi, hilo_lo}, {xh, xl});
            chk({name, " stall_wb"}, 64'(stall_o), 64'd0);
        end
        m_hi = xh; m_lo = xl;
        @(negedge clk);
        #1;
        chk({name, " after busy/done/we"}, 64'({busy, done, hilo_we}), 64'd0);
        chk({name, " hold"}, {hilo_hi, hilo_lo}, {m_hi, m_lo});
    endtask

    initial begin
        vec_t tbl[11];
        res_t r;
        int   lat, ndone;
        logic [31:0] cap_hi, cap_lo;
        logic [1:0]  cap_we;

        tbl[0]  = '{"MULT neg",     3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
        tbl[1]  = '{"MULTU max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 32'h0000_0001, 34};
        tbl[2]  = '{"DIV neg",      3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        tbl[3]  = '{"DIVU 7/2",     3'd3, 32'h0000_0007, 32'h0000_0002, 2'b11, 32'h0000_0001, 32'h0000_0003, 34};
        tbl[4]  = '{"MTHI",         3'd4, 32'h1234_5678, 32'h0000_0000, 2'b10, 32'h1234_5678, 32'h0,         1};
        tbl[5]  = '{"DIV by zero",  3'd2, 32'h0000_0005, 32'h0000_0000, 2'b00, 32'h0,         32'h0,         1};
        tbl[6]  = '{"DIV overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 32'h8000_0000, 34};
        tbl[7]  = '{"MTLO",         3'd5, 32'hCAFE_F00D, 32'h0000_0000, 2'b01, 32'h0,         32'hCAFE_F00D, 1};
        tbl[8]  = '{"MULT minmin",  3'd0, 32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000, 32'h0000_0000, 34};
        tbl[9]  = '{"DIVU by 1",    3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 34};
        tbl[10] = '{"DIV 7/-2",     3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 2'b11, 32'h0000_0001, 32'hFFFF_FFFD, 34};

        // Reset values
        #2 rst = 1'b0;
        #1;
        chk("reset outputs", {27'd0, busy, stall_o, done, hilo_we, hilo_hi}, 64'd0);
        chk("reset lo", 64'(hilo_lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].we, tbl[i].hi, tbl[i].lo, tbl[i].lat);
        end

        // Illegal op is ignored
        @(negedge clk);
        op = 3'd6; src_a = 32'h55; start = 1'b1;
        #1 chk("illegal stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1 chk("illegal busy/done", 64'({busy, done}), 64'd0);

        // start dropped when cancel is high in IDLE
        @(negedge clk);
        op = 3'd0; src_a = 32'd3; src_b = 32'd4; start = 1'b1; cancel = 1'b1;
        #1 chk("idle cancel stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1 chk("idle cancel busy", 64'(busy), 64'd0);

        // DIV cancelled at cycle 10, MTLO issued at cycle 11 writes at cycle 12
        @(negedge clk);
        op = 3'd2; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 chk("div c10 busy", 64'({busy, done, hilo_we}), 64'b1000);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1 chk("div cancel c11", 64'({busy, done, hilo_we}), 64'd0);
        op = 3'd5; src_a = 32'hA5A5_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 chk("mtlo after cancel", {30'd0, done, hilo_we, hilo_lo}, {30'd0, 1'b1, 2'b01, 32'hA5A5_0001});
        m_lo = 32'hA5A5_0001;
        chk("mtlo after cancel hi", 64'(hilo_hi), 64'(m_hi));

        // start while busy is ignored
        @(negedge clk);
        op = 3'd1; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        lat = 0; ndone = 0; cap_we = '0; cap_hi = '0; cap_lo = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 5);
            op    = (c == 5) ? 3'd4 : 3'd1;
            src_a = (c == 5) ? 32'hDEAD_BEEF : 32'd3;
            #1;
            if (done) begin
                ndone++;
                if (lat == 0) begin lat = c; cap_we = hilo_we; cap_hi = hilo_hi; cap_lo = hilo_lo; end
            end
        end
        chk("busy start latency", 64'(lat), 64'd34);
        chk("busy start done count", 64'(ndone), 64'd1);
        chk("busy start result", {cap_hi, cap_lo}, {32'd0, 32'd15});
        chk("busy start we", 64'(cap_we), 64'b11);
        m_hi = 32'd0; m_lo = 32'd15;

        // cancel in the WB cycle gates the pulse
        @(negedge clk);
        op = 3'd4; src_a = 32'h0BAD_0BAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b1;
        #1 chk("wb cancel gate", 64'({busy, done, hilo_we}), 64'b1000);
        @(negedge clk);
        cancel = 1'b0;
        #1 chk("wb cancel idle", 64'({busy, done}), 64'd0);
        r = ref_model(3'd1, 32'h0001_0000, 32'h0003_0000);
        do_op("resync MULTU", 3'd1, 32'h0001_0000, 32'h0003_0000, r.we, r.hi, r.lo, r.lat);

        // Reset mid-MULT: immediate return to reset values, no write afterwards
        @(negedge clk);
        op = 3'd0; src_a = 32'hFFFF_0001; src_b = 32'd9; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("rst mid outputs", {27'd0, busy, stall_o, done, hilo_we, hilo_hi}, 64'd0);
        chk("rst mid lo", 64'(hilo_lo), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done || busy || hilo_we != 2'b00) ndone++;
        end
        chk("rst no write", 64'(ndone), 64'd0);

        // Random ops against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            int          k;
            o = 3'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0) b = 32'd0;
            else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (k == 2) b = 32'($urandom_range(1, 15));
            else if (k == 3) b = 32'd0 - 32'($urandom_range(1, 15));
            r = ref_model(o, a, b);
            do_op($sformatf("rand%0d op%0d", n, o), o, a, b, r.we, r.hi, r.lo, r.lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
